// File: rtl/spi_mem_master.sv
// spi_mem_master
// Host-side SPI master that turns one memory request at a time into the
// two-frame protocol of the SPI-slave/RAM wrapper: an address frame followed
// by a data frame. Read data is shifted in from MISO after a fixed latency
// and handed back on a one-cycle response strobe.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  controller idle, request accepted when req_valid && req_ready
//   req_write  1 = write, 0 = read
//   req_addr   RAM address
//   req_wdata  write data, ignored for reads
//   rsp_valid  one-cycle pulse carrying read data
//   rsp_rdata  read data, held until the next rsp_valid
//   op_done    one-cycle pulse at the end of every request
//   SS_n       slave select to the wrapper, active low
//   MOSI       serial data to the wrapper
//   MISO       serial data from the wrapper
module spi_mem_master #(
   parameter int READ_LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       op_done,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CMD     = 3'd1;
   localparam logic [2:0] S_SHIFT   = 3'd2;
   localparam logic [2:0] S_RD_WAIT = 3'd3;
   localparam logic [2:0] S_CAPTURE = 3'd4;
   localparam logic [2:0] S_GAP     = 3'd5;

   localparam logic [3:0] LAT_LAST = 4'(READ_LAT - 1);

   logic [2:0] r_state;
   logic       r_write;
   logic [7:0] r_addr;
   logic [7:0] r_wdata;
   logic       r_frameIdx;
   logic [3:0] r_bitCnt;
   logic [3:0] r_waitCnt;
   logic [7:0] r_cap;
   logic [7:0] r_rdata;

   logic [9:0] w_frame;
   logic [3:0] w_bitIdx;
   logic       w_mosi;
   logic       w_lastGap;

   // The frame word is rebuilt from the latched request and the frame index,
   // so nothing on the req_* inputs can disturb a transaction once accepted.
   always_comb begin
      w_frame = 10'h000;
      case ({r_write, r_frameIdx})
         2'b10:   w_frame = {2'b00, r_addr};
         2'b11:   w_frame = {2'b01, r_wdata};
         2'b00:   w_frame = {2'b10, r_addr};
         default: w_frame = {2'b11, 8'h00};
      endcase
   end

   // CMD repeats the top bit, then SHIFT walks the word MSB first.
   // MOSI is forced low in every other state, including while deselected.
   assign w_bitIdx = 4'd9 - r_bitCnt;

   always_comb begin
      w_mosi = 1'b0;
      case (r_state)
         S_CMD:   w_mosi = w_frame[9];
         S_SHIFT: w_mosi = w_frame[w_bitIdx];
         default: w_mosi = 1'b0;
      endcase
   end

   // Outputs decode straight from the registered state so that an
   // asynchronous reset drives them to their idle values immediately.
   assign w_lastGap = (r_state == S_GAP) && r_frameIdx;
   assign req_ready = (r_state == S_IDLE);
   assign SS_n      = (r_state == S_IDLE) || (r_state == S_GAP);
   assign MOSI      = w_mosi;
   assign op_done   = w_lastGap;
   assign rsp_valid = w_lastGap && !r_write;
   assign rsp_rdata = rsp_valid ? r_cap : r_rdata;

   // Main sequencer: accepts a request, plays the address and data frames,
   // waits out the read latency, captures the returned byte, and separates
   // frames with a one-cycle deselect gap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_write    <= 1'b0;
         r_addr     <= 8'h00;
         r_wdata    <= 8'h00;
         r_frameIdx <= 1'b0;
         r_bitCnt   <= 4'd0;
         r_waitCnt  <= 4'd0;
         r_cap      <= 8'h00;
         r_rdata    <= 8'h00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write    <= req_write;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_frameIdx <= 1'b0;
                  r_bitCnt   <= 4'd0;
                  r_state    <= S_CMD;
               end
            end
            S_CMD: begin
               r_bitCnt <= 4'd0;
               r_state  <= S_SHIFT;
            end
            S_SHIFT: begin
               if (r_bitCnt == 4'd9) begin
                  r_bitCnt  <= 4'd0;
                  r_waitCnt <= 4'd0;
                  r_state   <= (w_frame[9:8] == 2'b11) ? S_RD_WAIT : S_GAP;
               end else begin
                  r_bitCnt <= r_bitCnt + 4'd1;
               end
            end
            S_RD_WAIT: begin
               if (r_waitCnt == LAT_LAST) begin
                  r_waitCnt <= 4'd0;
                  r_bitCnt  <= 4'd0;
                  r_state   <= S_CAPTURE;
               end else begin
                  r_waitCnt <= r_waitCnt + 4'd1;
               end
            end
            S_CAPTURE: begin
               r_cap <= {r_cap[6:0], MISO};
               if (r_bitCnt == 4'd7) begin
                  r_bitCnt <= 4'd0;
                  r_state  <= S_GAP;
               end else begin
                  r_bitCnt <= r_bitCnt + 4'd1;
               end
            end
            S_GAP: begin
               if (!r_frameIdx) begin
                  r_frameIdx <= 1'b1;
                  r_state    <= S_CMD;
               end else begin
                  r_frameIdx <= 1'b0;
                  r_state    <= S_IDLE;
                  if (!r_write) begin
                     r_rdata <= r_cap;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_mem_master.md
# spi_mem_master

Host-side SPI master controller that sequences memory transactions into the SPI-slave/RAM wrapper. It accepts one write or read request at a time over a valid/ready handshake. Each request is expanded into the two-frame SPI protocol the slave expects: an address frame followed by a data frame. Read data shifted back on MISO is returned on a one-cycle response strobe. The block sits between the test/host logic and the wrapper's SS_n/MOSI/MISO pins, all on the wrapper clock.

## Interface
- READ_LAT, default 2: cycles between the last MOSI bit of a read-data frame and the first MISO data bit. Legal range 1..15.
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  8  RAM address.
- req_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse carrying read data.
- rsp_rdata  out  8  read data; holds its value until the next rsp_valid.
- op_done  out  1  one-cycle pulse at the end of every request, read or write.
- SS_n  out  1  slave select to wrapper, active low.
- MOSI  out  1  serial data to wrapper.
- MISO  in  1  serial data from wrapper.

## Operation
- Frame word W[9:0] = {cmd[1:0], payload[7:0]}.
  - cmd 00: write address.
  - cmd 01: write data.
  - cmd 10: read address.
  - cmd 11: read data; payload 8'h00.
- Write request sends frame {00,addr}, then frame {01,wdata}. Read request sends frame {10,addr}, then frame {11,8'h00}.
- Request fields are latched on acceptance. Later changes on req_* inputs have no effect on the transaction in progress.
- FSM states: IDLE, CMD, SHIFT, RD_WAIT, CAPTURE, GAP.
  - IDLE: req_ready=1, SS_n=1. On accept go to CMD with frame index 0.
  - CMD (1 cycle): SS_n=0, MOSI=W[9] (read/write select bit). Go to SHIFT.
  - SHIFT (10 cycles): SS_n=0, MOSI=W[9] down to W[0], MSB first, 4-bit bit counter. After W[0]:
    - frame {11,..}: go to RD_WAIT.
    - otherwise: go to GAP.
  - RD_WAIT (READ_LAT cycles): SS_n=0, MOSI=0. Go to CAPTURE.
  - CAPTURE (8 cycles): SS_n=0, MOSI=0. Shift MISO into an 8-bit register MSB first, one bit per posedge. Go to GAP.
  - GAP (1 cycle): SS_n=1, MOSI=0.
    - If frame index is 0: set index to 1 and go to CMD.
    - Else: pulse op_done and go to IDLE. On reads, also pulse rsp_valid and load rsp_rdata from the capture register in the same cycle.
- req_ready is 0 in every state except IDLE. req_valid while busy is neither accepted nor queued.
- MOSI is 0 whenever SS_n=1.
- Reset values: SS_n=1, MOSI=0, req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=8'h00, op_done=0, capture register 0, all counters 0.
- Reset asserted mid-operation:
  - Outputs take their reset values immediately (asynchronous).
  - The in-flight request is dropped with no rsp_valid and no op_done.
  - After rst_n rises, the block is in IDLE.

## Timing
- Acceptance edge = cycle T. SS_n is first low in cycle T+1 (CMD).
- Write frame: 11 SS_n-low cycles, then 1 GAP cycle.
- Write request: SS_n low T+1..T+11, high T+12, low T+13..T+23, high T+24. op_done=1 in cycle T+24. req_ready=1 from T+25.
- Read-data frame: 11+READ_LAT+8 SS_n-low cycles.
- Read request total: 12 + (11+READ_LAT+8) + 1 cycles after T. With READ_LAT=2, rsp_valid and op_done are high in cycle T+34 and req_ready=1 from T+35.
- Back-to-back: a request held valid in IDLE is accepted on the first IDLE edge. Minimum gap between consecutive frames of different requests = GAP + IDLE = 2 SS_n-high cycles.
- MISO is sampled on the posedge ending each CAPTURE cycle. Bit 7 is sampled READ_LAT cycles after the W[0] cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_rdata=00.
- Write addr 8'h3C, data 8'hA5 -> MOSI frames 0,0000111100 then 0,0110100101. op_done at T+24. No rsp_valid.
- Read addr 8'h3C after the write above, with a wrapper model returning A5 -> frames 1,1000111100 and 1,1100000000. rsp_rdata=8'hA5 with rsp_valid at T+34 (READ_LAT=2). Repeat with READ_LAT=1 and READ_LAT=15; rsp_valid moves to T+33 and T+47.
- Back-to-back write(00,FF) then read(00) with req_valid held high -> second accept in the cycle after op_done. rsp_rdata=FF.
- Toggle req_valid and req_addr during a busy write -> no extra acceptance. Frames carry the latched address.
- Assert rst_n=0 during read SHIFT bit 5 -> SS_n=1 within the same cycle, no rsp_valid, no op_done. A new read after release completes normally.
